calc_sequencer: RTL and testbench

- Top-level controller for the calculator datapath.
- Walks an inclusive range of 64-bit memory words. Each word supplies two 32-bit operands (lower = A, upper = B) to the adder.
- Steers each sum into the low or high half of result_buffer via loc_sel.
- Once both halves hold results, writes the packed 64-bit buffer word back to memory at an incrementing write address.

---
 rtl/calculator_pkg.sv | 19 +
 rtl/calc_sequencer.sv | 128 ++++++++++++
 tb/tb_calc_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/calculator_pkg.sv
// Shared widths and sequencer state encoding for the calculator datapath.
package calculator_pkg;

   localparam int ADDR_W        = 10;
   localparam int DATA_W        = 32;
   localparam int MEM_WORD_SIZE = 64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LOAD,
      S_ADD,
      S_PAD,
      S_PADADD,
      S_WRITE,
      S_DONE
   } state_t;

endpackage

// File: rtl/calc_sequencer.sv
// Walks a memory range, feeds word halves to the adder, packs two sums per
// result_buffer word and writes each packed word back to memory.
module calc_sequencer
   import calculator_pkg::*;
#(
   parameter int ADDR_W        = calculator_pkg::ADDR_W,
   parameter int DATA_W        = calculator_pkg::DATA_W,
   parameter int MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic [ADDR_W-1:0]        rd_start_addr_i,
   input  logic [ADDR_W-1:0]        rd_end_addr_i,
   input  logic [ADDR_W-1:0]        wr_start_addr_i,
   output logic                     mem_rd_en_o,
   output logic                     mem_wr_en_o,
   output logic [ADDR_W-1:0]        mem_addr_o,
   input  logic [MEM_WORD_SIZE-1:0] mem_rd_data_i,
   output logic [DATA_W-1:0]        op_a_o,
   output logic [DATA_W-1:0]        op_b_o,
   output logic                     loc_sel_o,
   input  logic [MEM_WORD_SIZE-1:0] buffer_i,
   output logic                     busy_o,
   output logic                     done_o
);

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   rd_ptr_reg, rd_ptr_next;
   logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [ADDR_W-1:0]   rd_end_reg, rd_end_next;
   logic [DATA_W-1:0]   op_a_reg, op_a_next;
   logic [DATA_W-1:0]   op_b_reg, op_b_next;
   logic                loc_sel_reg, loc_sel_next;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= S_IDLE;
         rd_ptr_reg  <= '0;
         wr_ptr_reg  <= '0;
         rd_end_reg  <= '0;
         op_a_reg    <= '0;
         op_b_reg    <= '0;
         loc_sel_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         rd_ptr_reg  <= rd_ptr_next;
         wr_ptr_reg  <= wr_ptr_next;
         rd_end_reg  <= rd_end_next;
         op_a_reg    <= op_a_next;
         op_b_reg    <= op_b_next;
         loc_sel_reg <= loc_sel_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      rd_ptr_next  = rd_ptr_reg;
      wr_ptr_next  = wr_ptr_reg;
      rd_end_next  = rd_end_reg;
      op_a_next    = op_a_reg;
      op_b_next    = op_b_reg;
      loc_sel_next = loc_sel_reg;
      case (state_reg)
         S_IDLE: begin
            if (start_i) begin
               rd_ptr_next  = rd_start_addr_i;
               wr_ptr_next  = wr_start_addr_i;
               rd_end_next  = rd_end_addr_i;
               loc_sel_next = 1'b0;
               state_next   = (rd_end_addr_i < rd_start_addr_i) ? S_DONE : S_READ;
            end
         end
         S_READ: state_next = S_LOAD;
         S_LOAD: begin
            op_a_next  = mem_rd_data_i[DATA_W-1:0];
            op_b_next  = mem_rd_data_i[MEM_WORD_SIZE-1:DATA_W];
            state_next = S_ADD;
         end
         S_ADD: begin
            if (loc_sel_reg) begin
               state_next = S_WRITE;
            end else if (rd_ptr_reg != rd_end_reg) begin
               // Equality test keeps rd_end at the top of the address space safe.
               loc_sel_next = 1'b1;
               rd_ptr_next  = rd_ptr_reg + ADDR_W'(1);
               state_next   = S_READ;
            end else begin
               state_next = S_PAD;
            end
         end
         S_PAD: begin
            op_a_next    = '0;
            op_b_next    = '0;
            loc_sel_next = 1'b1;
            state_next   = S_PADADD;
         end
         S_PADADD: state_next = S_WRITE;
         S_WRITE: begin
            wr_ptr_next  = wr_ptr_reg + ADDR_W'(1);
            loc_sel_next = 1'b0;
            if (rd_ptr_reg == rd_end_reg) begin
               state_next = S_DONE;
            end else begin
               rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
               state_next  = S_READ;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   assign mem_rd_en_o = (state_reg == S_READ);
   assign mem_wr_en_o = (state_reg == S_WRITE);
   assign mem_addr_o  = (state_reg == S_READ)  ? rd_ptr_reg :
                        (state_reg == S_WRITE) ? wr_ptr_reg : '0;
   assign op_a_o      = op_a_reg;
   assign op_b_o      = op_b_reg;
   assign loc_sel_o   = loc_sel_reg;
   assign busy_o      = (state_reg != S_IDLE);
   assign done_o      = (state_reg == S_DONE);

   // Write data comes straight from result_buffer outside this block.
   logic unused_buffer;
   assign unused_buffer = ^buffer_i;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench: memory, adder and result_buffer models around the
// sequencer, checked against a word-level reference of the packed output.
module tb_calc_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  rd_start = '0, rd_end = '0, wr_start = '0;
   logic        mem_rd_en, mem_wr_en;
   logic [9:0]  mem_addr;
   logic [63:0] rd_data = '0;
   logic [31:0] op_a, op_b;
   logic        loc_sel;
   logic [63:0] buffer = '0;
   logic        busy, done;

   logic        pl_en = 1'b0;
   logic [9:0]  pl_addr = '0;
   logic [63:0] pl_data = '0;
   logic [63:0] mem [1024];
   logic [63:0] ref_mem [1024];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   calc_sequencer dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .rd_start_addr_i(rd_start), .rd_end_addr_i(rd_end), .wr_start_addr_i(wr_start),
      .mem_rd_en_o(mem_rd_en), .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr),
      .mem_rd_data_i(rd_data), .op_a_o(op_a), .op_b_o(op_b), .loc_sel_o(loc_sel),
      .buffer_i(buffer), .busy_o(busy), .done_o(done)
   );

   // Environment: memory with registered read, 32-bit adder, result_buffer.
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (mem_wr_en) mem[mem_addr] <= buffer;
      if (mem_rd_en) rd_data <= mem[mem_addr];
      if (rst) buffer <= '0;
      else if (loc_sel) buffer[63:32] <= op_a + op_b;
      else buffer[31:0] <= op_a + op_b;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sum32(input logic [63:0] w);
      return w[31:0] + w[63:32];
   endfunction

   task automatic preload(input int a, input logic [63:0] d);
      pl_addr = a[9:0];
      pl_data = d;
      pl_en   = 1'b1;
      @(negedge clk);
      pl_en = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic run_check(input int rs, input int re, input int ws, input int inj);
      int n, nw, exp_done, idx, didx, dcount, bcount;
      logic [63:0] exp_q[$];
      int rdq[$];
      int wrq[$];
      logic [31:0] lo, hi;
      n        = (re >= rs) ? re - rs + 1 : 0;
      nw       = (n + 1) / 2;
      exp_done = 7 * (n / 2) + 6 * (n % 2);
      for (int k = 0; k < nw; k++) begin
         lo = sum32(ref_mem[(rs + 2*k) % 1024]);
         hi = (2*k + 1 < n) ? sum32(ref_mem[(rs + 2*k + 1) % 1024]) : 32'h0;
         exp_q.push_back({hi, lo});
      end
      rd_start = rs[9:0];
      rd_end   = re[9:0];
      wr_start = ws[9:0];
      start    = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      didx   = -1;
      dcount = 0;
      bcount = 0;
      idx    = 0;
      while (idx < exp_done + 30) begin
         if (mem_rd_en) rdq.push_back(int'(mem_addr));
         if (mem_wr_en) wrq.push_back(int'(mem_addr));
         if (mem_rd_en && mem_wr_en) check("rd_wr_overlap", 64'd1, 64'd0);
         if (busy) bcount++;
         if (done) begin
            dcount++;
            if (didx < 0) didx = idx;
         end
         if (didx >= 0 && idx > didx) break;
         if (idx == inj) begin
            start    = 1'b1;
            rd_start = 10'($urandom);
            rd_end   = 10'($urandom);
            wr_start = 10'($urandom);
         end else if (idx == inj + 1) begin
            start    = 1'b0;
            rd_start = rs[9:0];
            rd_end   = re[9:0];
            wr_start = ws[9:0];
         end
         @(negedge clk);
         idx++;
      end
      check("done_count", dcount, 1);
      check("done_cycle", didx, exp_done);
      check("busy_cycles", bcount, exp_done + 1);
      check("rd_count", rdq.size(), n);
      for (int k = 0; k < n && k < rdq.size(); k++)
         check("rd_addr", rdq[k], (rs + k) % 1024);
      check("wr_count", wrq.size(), nw);
      for (int k = 0; k < nw && k < wrq.size(); k++)
         check("wr_addr", wrq[k], (ws + k) % 1024);
      for (int k = 0; k < nw; k++) begin
         check("wr_data", mem[(ws + k) % 1024], exp_q[k]);
         ref_mem[(ws + k) % 1024] = exp_q[k];
      end
      $display("run rd %0d..%0d wr %0d: %0d words read, %0d written, done at cycle %0d",
               rs, re, ws, rdq.size(), wrq.size(), didx);
   endtask

   initial begin
      int rs, n, ws, inj;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_rd_en", mem_rd_en, 0);
      check("rst_wr_en", mem_wr_en, 0);
      check("rst_done", done, 0);
      check("rst_op_a", op_a, 0);
      check("rst_loc_sel", loc_sel, 0);
      rst = 1'b0;
      @(negedge clk);

      preload(0, {32'd2, 32'd1});
      preload(1, {32'd20, 32'd10});
      run_check(0, 1, 8, -1);
      check("two_word_mem8", mem[8], 64'h0000001E_00000003);

      preload(2, {32'd5, 32'd4});
      run_check(0, 2, 8, -1);
      check("odd_mem9", mem[9], 64'h00000000_00000009);

      run_check(5, 4, 0, -1);

      preload(1022, {32'd1, 32'hFFFFFFFF});
      preload(1023, {32'd3, 32'd4});
      run_check(1022, 1023, 1023, -1);
      check("wrap_mem1023", mem[1023], 64'h00000007_00000000);

      preload(3, {32'd100, 32'd7});
      run_check(0, 3, 16, 4);

      // Reset during the first ADD cycle, then a clean restart.
      rd_start = 10'd0;
      rd_end   = 10'd3;
      wr_start = 10'd32;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_rd_en", mem_rd_en, 0);
      check("midrst_wr_en", mem_wr_en, 0);
      check("midrst_op_a", op_a, 0);
      check("midrst_op_b", op_b, 0);
      check("midrst_loc_sel", loc_sel, 0);
      @(negedge clk);
      check("postrst_rd_en", mem_rd_en, 0);
      check("postrst_busy", busy, 0);
      run_check(0, 3, 32, -1);

      for (int r = 0; r < 5; r++) begin
         rs  = $urandom_range(100, 400);
         n   = $urandom_range(1, 9);
         ws  = rs + 512;
         inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : -1;
         for (int k = 0; k < n; k++) preload(rs + k, {$urandom, $urandom});
         run_check(rs, rs + n - 1, ws, inj);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
